// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller at the M stage: SR, Cause, EPC, PRId.
// req and cp0_rdata are combinational; state updates one edge later. No flow control.
module cp0_unit #(
    parameter logic [31:0] PRID    = 32'h2025_0001,
    parameter int          HWINT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    input  logic [31:0]        vpc,
    input  logic               bd_in,
    input  logic [4:0]         exc_code_in,
    input  logic [HWINT_W-1:0] hw_int,
    input  logic               exl_clr,
    output logic [31:0]        epc_out,
    output logic               req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [HWINT_W-1:0] r_im;
    logic               r_exl;
    logic               r_ie;
    logic               r_bd;
    logic [HWINT_W-1:0] r_ip;
    logic [4:0]         r_exc_code;
    logic [29:0]        r_epc;

    logic               w_int_req;
    logic               w_exc_req;
    logic               w_req;
    logic [31:0]        w_epc_next;
    logic [31:0]        w_sr;
    logic [31:0]        w_cause;
    logic               w_wr_sr;
    logic               w_wr_epc;
    logic               w_unused_bits;

    assign w_int_req = (|(hw_int & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (exc_code_in != 5'd0) & ~r_exl;
    assign w_req     = w_int_req | w_exc_req;
    assign req       = w_req;

    // A delay-slot victim restarts at the branch so the branch is re-executed.
    assign w_epc_next = bd_in ? (vpc - 32'd4) : vpc;

    assign w_wr_sr  = en && (cp0_addr == ADDR_SR);
    assign w_wr_epc = en && (cp0_addr == ADDR_EPC);

    assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
    assign epc_out = {r_epc, 2'b00};

    assign w_unused_bits = ^{w_epc_next[1:0], cp0_wdata[31:16], cp0_wdata[9:2]};

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = w_sr;
            ADDR_CAUSE: cp0_rdata = w_cause;
            ADDR_EPC:   cp0_rdata = epc_out;
            ADDR_PRID:  cp0_rdata = PRID;
            default:    cp0_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exc_code <= 5'd0;
            r_epc      <= 30'd0;
        end else begin
            r_ip <= hw_int;
            if (w_req) begin
                // Entry wins over any concurrent mtc0 or eret.
                r_exl      <= 1'b1;
                r_bd       <= bd_in;
                r_exc_code <= w_int_req ? 5'd0 : exc_code_in;
                r_epc      <= w_epc_next[31:2];
            end else begin
                if (w_wr_sr) begin
                    r_im  <= cp0_wdata[15:10];
                    r_ie  <= cp0_wdata[0];
                    r_exl <= cp0_wdata[1] & ~exl_clr;
                end else if (exl_clr) begin
                    r_exl <= 1'b0;
                end
                if (w_wr_epc) begin
                    r_epc <= cp0_wdata[31:2];
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit with hand-computed expected register values.
module tb_cp0_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] epc_out;
    logic        req;

    int n_checks = 0;
    int n_errors = 0;

    cp0_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .exl_clr     (exl_clr),
        .epc_out     (epc_out),
        .req         (req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        #1;
        check_val(tag, cp0_rdata, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
        vpc = 32'd0; bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; exl_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rd("rst_sr_in_reset", 5'd12, 32'd0);
        check_val("rst_req_in_reset", {31'd0, req}, 32'd0);
        rst_n = 1'b1;
        #1;
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);
        rd("prid", 5'd15, 32'h2025_0001);
        rd("unimpl_reg", 5'd5, 32'd0);
        check_val("rst_epc_out", epc_out, 32'd0);
        hw_int = 6'h3f;
        #1;
        check_val("idle_req_masked", {31'd0, req}, 32'd0);
        tick();
        rd("ip_sample", 5'd13, 32'h0000_fc00);

        // Interrupt entry
        hw_int = 6'd0;
        en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
        tick();
        en = 1'b0;
        rd("sr_write", 5'd12, 32'h0000_0401);
        check_val("req_no_int", {31'd0, req}, 32'd0);
        hw_int = 6'b000001; vpc = 32'h0000_3010; bd_in = 1'b0;
        #1;
        check_val("int_req", {31'd0, req}, 32'd1);
        tick();
        rd("int_sr", 5'd12, 32'h0000_0403);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_epc", 5'd14, 32'h0000_3010);
        check_val("int_epc_out", epc_out, 32'h0000_3010);
        check_val("int_req_exl", {31'd0, req}, 32'd0);

        // eret with interrupt still pending
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        check_val("eret_req_again", {31'd0, req}, 32'd1);
        hw_int = 6'd0;
        #1;
        check_val("req_int_gone", {31'd0, req}, 32'd0);

        // Delay-slot exception
        exc_code_in = 5'd12; vpc = 32'h0000_3024; bd_in = 1'b1;
        #1;
        check_val("bd_exc_req", {31'd0, req}, 32'd1);
        tick();
        exc_code_in = 5'd0; bd_in = 1'b0;
        rd("bd_epc", 5'd14, 32'h0000_3020);
        rd("bd_cause", 5'd13, 32'h8000_0030);
        rd("bd_sr", 5'd12, 32'h0000_0403);

        // Nested fault masked, Cause not writable
        exc_code_in = 5'd4; hw_int = 6'b000001;
        en = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hffff_ffff;
        #1;
        check_val("nested_req", {31'd0, req}, 32'd0);
        tick();
        en = 1'b0; exc_code_in = 5'd0;
        rd("cause_ro", 5'd13, 32'h8000_0430);
        rd("nested_epc", 5'd14, 32'h0000_3020);
        hw_int = 6'd0; exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        rd("eret2_sr", 5'd12, 32'h0000_0401);

        // Interrupt beats exception; concurrent mtc0 and eret are dropped
        hw_int = 6'b000001; exc_code_in = 5'd10; vpc = 32'h0000_3100; bd_in = 1'b0;
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234; exl_clr = 1'b1;
        #1;
        check_val("both_req", {31'd0, req}, 32'd1);
        tick();
        en = 1'b0; exl_clr = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0;
        rd("both_cause", 5'd13, 32'h0000_0400);
        rd("both_epc", 5'd14, 32'h0000_3100);
        rd("both_sr", 5'd12, 32'h0000_0403);

        // eret with simultaneous SR write
        exl_clr = 1'b1; en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0803;
        tick();
        en = 1'b0; exl_clr = 1'b0;
        rd("eret_mtc0_sr", 5'd12, 32'h0000_0801);
        check_val("eret_mtc0_req", {31'd0, req}, 32'd0);

        // EPC write aligns, read shows old value before the edge
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007;
        #1;
        check_val("epc_no_bypass", cp0_rdata, 32'h0000_3100);
        tick();
        en = 1'b0;
        check_val("epc_align_out", epc_out, 32'h0000_3004);
        rd("epc_align_rd", 5'd14, 32'h0000_3004);

        // Asynchronous reset drops a live request
        hw_int = 6'b000010;
        #1;
        check_val("im11_req", {31'd0, req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_req", {31'd0, req}, 32'd0);
        check_val("async_rst_epc", epc_out, 32'd0);
        rd("async_rst_sr", 5'd12, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline; sits at the M stage.
- Decides when the pipeline must divert to the kernel handler and drives the `req` flag the PC-select logic consumes.
- Captures the victim PC, cause and branch-delay status.
- Supplies `epc_out` for `eret`, which closes the loop back from the handler to user code.
- Also serves `mfc0`/`mtc0` register accesses.

Parameters:
- PRID, 32'h2025_0001, constant value returned for PRId (reg 15).
- HWINT_W, 6, number of hardware interrupt lines; fixed to 6 for field mapping.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  mtc0 write enable (M stage).
- cp0_addr  in  5  register number for mtc0 write and mfc0 read.
- cp0_wdata  in  32  mtc0 write data.
- cp0_rdata  out  32  mfc0 read data (combinational).
- vpc  in  32  PC of the M-stage instruction (victim PC).
- bd_in  in  1  M-stage instruction sits in a branch delay slot.
- exc_code_in  in  5  synchronous exception code from the pipeline; 0 = none.
- hw_int  in  6  external interrupt lines, level-sensitive.
- exl_clr  in  1  eret executing in M stage.
- epc_out  out  32  current EPC register.
- req  out  1  divert to the kernel handler this cycle (combinational).

Behaviour:
- Registers:
  - SR (12): IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
  - EPC (14): 32 bits.
- Reset (rst_n = 0, asynchronous): SR, Cause and EPC all 0. Consequently req = 0, epc_out = 0, cp0_rdata = 0 for regs 12/13/14.
- Request logic (combinational):
  - int_req = (|(hw_int & SR.IM)) & SR.IE & ~SR.EXL.
  - exc_req = (exc_code_in != 0) & ~SR.EXL.
  - req = int_req | exc_req.
- On posedge with req = 1 (highest priority):
  - EXL <= 1.
  - BD <= bd_in.
  - ExcCode <= int_req ? 0 : exc_code_in. Interrupt beats a simultaneous exception.
  - EPC <= bd_in ? vpc - 4 : vpc, with bits [1:0] forced to 0.
  - Any mtc0 in the same cycle is discarded.
  - exl_clr in the same cycle is ignored. EXL ends at 1.
- Else, on posedge with exl_clr = 1: EXL <= 0. Other fields are unchanged unless mtc0 also targets them. If mtc0 writes SR in the same cycle, IM and IE take the written values and EXL = 0.
- Else, on posedge with en = 1:
  - addr 12: IM, EXL and IE take cp0_wdata bits [15:10], [1], [0].
  - addr 14: EPC <= cp0_wdata[31:2], 2'b00.
  - Writes to 13, 15 and any other address are ignored. Cause is read-only to software.
- Cause.IP <= hw_int on every posedge regardless of req, en or exl_clr (free-running sample).
- Read (combinational, no latency):
  - addr 12/13/14 return the masked register.
  - addr 15 returns PRID.
  - All other addresses return 0.
  - Reads reflect state before the current edge. There is no write-through bypass; the pipeline's forwarding logic handles it.
- epc_out = EPC register, always valid, 0-cycle latency.
- While EXL = 1, no new req is generated. Nested exceptions are masked; faults inside the handler are silently dropped.
- Reset asserted mid-handler clears EXL immediately. req drops asynchronously with state.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release; mfc0 12/13/14 -> 0; mfc0 15 -> 32'h2025_0001; req = 0 with hw_int = 6'h3f.
- Interrupt entry: mtc0 12 <= 32'h0000_0401 (IM[10], IE), hw_int = 6'b000001, vpc = 32'h0000_3010, bd_in = 0 -> req = 1 that cycle. Next cycle: EXL = 1, Cause = 32'h0000_0400, EPC = 32'h0000_3010, req = 0.
- Delay-slot exception: exc_code_in = 5'd12, vpc = 32'h0000_3024, bd_in = 1 -> req = 1. Next cycle: EPC = 32'h0000_3020, Cause = 32'h8000_0030.
- Simultaneous interrupt and exception: IE = 1, IM matching hw_int, exc_code_in = 5'd10 -> ExcCode = 0. Same cycle, mtc0 14 <= 32'h1234 -> write is lost and EPC = vpc.
- eret: with EXL = 1, pulse exl_clr -> next cycle SR.EXL = 0, and req reasserts if the interrupt is still pending and enabled. Also drive exc_code_in = 4 while EXL = 1 -> req stays 0.
- mtc0 14 <= 32'h0000_3007 -> epc_out = 32'h0000_3004 next cycle. mtc0 13 <= 32'hFFFF_FFFF -> Cause is unchanged.
